// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline front end.
//   - default datapath width and reset fetch address
//   - instruction-fetch state encoding
//   - NOP word that decode substitutes when IF/ID valid is low
package arm_pkg;

    localparam int unsigned BIT_NUMBER_DFLT = 32;
    localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_0000;

    // Fetch state encoding
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DROP  = 1'b1;

    // Sequential fetch increment (one 32-bit word)
    localparam int unsigned PC_STEP = 4;

    // MOV r0, r0 -- used by decode for bubbles
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

endpackage

// File: rtl/if_id_reg.sv
// Payload register with valid bit: used as the IF/ID pipeline register and
// as the one-entry fetch skid buffer.
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low clear (payload and valid)
//   load_i   capture data_i and set valid
//   flush_i  clear valid, payload kept (has priority over load_i)
//   data_i   payload in
//   data_o   payload out
//   valid_o  payload is meaningful
module if_id_reg #(
    parameter int unsigned W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Flush only drops valid so a bubble keeps the old payload visible
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory, skids one word across decode freezes and drives IF/ID.
//   clk, rst            clock, asynchronous active-low reset
//   freeze              hazard stall: hold IF/ID and PC
//   branch_taken/addr   redirect from EXE (flushes, may drop an in-flight fetch)
//   imem_req/addr       read request, address stable while req is high
//   imem_ack/rdata      read response
//   instruction/pc_out  IF/ID payload (pc_out = fetch PC + 4)
//   valid               IF/ID holds a real instruction
module if_stage
    import arm_pkg::*;
#(
    parameter int unsigned           BIT_NUMBER = BIT_NUMBER_DFLT,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = BIT_NUMBER'(RESET_PC_DFLT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_addr,
    output logic                  imem_req,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic [BIT_NUMBER-1:0] pc_out,
    output logic                  valid
);

    localparam int unsigned PAIR_W = 2 * BIT_NUMBER;

    logic [BIT_NUMBER-1:0] pc_q, pc_d;
    logic [BIT_NUMBER-1:0] target_q, target_d;
    logic [0:0]            state_q, state_d;
    logic [BIT_NUMBER-1:0] pc_plus4;

    logic              ack_ok;
    logic              fetch_ok;
    logic              hold_valid;
    logic [PAIR_W-1:0] fetch_word;
    logic [PAIR_W-1:0] hold_word;
    logic [PAIR_W-1:0] ifid_d;
    logic [PAIR_W-1:0] ifid_word;
    logic              skid_load, skid_flush;
    logic              ifid_load, ifid_flush;

    assign pc_plus4   = pc_q + BIT_NUMBER'(PC_STEP);
    // Request whenever the skid is empty; stays up in DROP to retire the stale fetch
    assign imem_req   = rst & ~hold_valid;
    assign imem_addr  = pc_q;
    assign ack_ok     = imem_req & imem_ack;
    // A returned word that is actually kept
    assign fetch_ok   = ack_ok & (state_q == FETCH) & ~branch_taken;
    assign fetch_word = {imem_rdata, pc_plus4};

    // Skid buffer catches a word that lands while decode is frozen
    assign skid_load  = fetch_ok & freeze;
    assign skid_flush = branch_taken | (hold_valid & ~freeze);

    if_id_reg #(.W(PAIR_W)) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .flush_i (skid_flush),
        .data_i  (fetch_word),
        .data_o  (hold_word),
        .valid_o (hold_valid)
    );

    // IF/ID: drain skid first, else take the fresh word, else bubble
    assign ifid_d     = hold_valid ? hold_word : fetch_word;
    assign ifid_load  = ~freeze & (fetch_ok | hold_valid);
    assign ifid_flush = branch_taken | (state_q == DROP)
                      | (~freeze & ~fetch_ok & ~hold_valid);

    if_id_reg #(.W(PAIR_W)) u_if_id (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .data_i  (ifid_d),
        .data_o  (ifid_word),
        .valid_o (valid)
    );

    assign instruction = ifid_word[PAIR_W-1:BIT_NUMBER];
    assign pc_out      = ifid_word[BIT_NUMBER-1:0];

    // PC / fetch-state next-state logic
    always_comb begin
        pc_d     = pc_q;
        target_d = target_q;
        state_d  = state_q;
        if (branch_taken) begin
            if (imem_req && !imem_ack) begin
                // Memory still owes us a word: park the target until it retires
                target_d = branch_addr;
                state_d  = DROP;
            end else begin
                pc_d    = branch_addr;
                state_d = FETCH;
            end
        end else if (state_q == DROP) begin
            if (ack_ok) begin
                pc_d    = target_q;
                state_d = FETCH;
            end
        end else if (fetch_ok) begin
            pc_d = pc_plus4;
        end
    end

    // PC / fetch-state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            target_q <= '0;
            state_q  <= FETCH;
        end else begin
            pc_q     <= pc_d;
            target_q <= target_d;
            state_q  <= state_d;
        end
    end

endmodule
